// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, operand type and feeder state encoding for the MAC-neuron feeder.
package mac_pkg;
  localparam int N_TAPS = 3;
  localparam int DATA_W = 8;
  localparam int ACC_W = 16;
  typedef logic signed [DATA_W-1:0] operand_t;
  typedef enum logic [2:0] {IDLE, START, WAIT_CLR, FEED, WAIT_DONE, RESP} state_t;
endpackage

// File: rtl/mac_operand_rf.sv
// mac_operand_rf: activation and weight register files, one write port, one tap-indexed read port.
module mac_operand_rf #(
  parameter int N_TAPS = mac_pkg::N_TAPS,
  parameter int DATA_W = mac_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic                        is_w,
  input  logic [$clog2(N_TAPS)-1:0]   addr,
  input  logic signed [DATA_W-1:0]    data,
  input  logic [$clog2(N_TAPS)-1:0]   k,
  output logic signed [DATA_W-1:0]    x,
  output logic signed [DATA_W-1:0]    w
);
  logic signed [DATA_W-1:0] act [N_TAPS];
  logic signed [DATA_W-1:0] wgt [N_TAPS];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        act[i] <= '0;
        wgt[i] <= '0;
      end
    end else if (we) begin
      if (is_w) wgt[addr] <= data;
      else act[addr] <= data;
    end
  end
  assign x = act[k];
  assign w = wgt[k];
endmodule

// File: rtl/mac_neuron_feeder.sv
// mac_neuron_feeder: loads operands, starts the neuron, streams taps aligned to its MAC cycles, returns the result.
module mac_neuron_feeder #(
  parameter int N_TAPS = mac_pkg::N_TAPS,
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W = mac_pkg::ACC_W,
  parameter int DONE_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic                        ld_is_w,
  input  logic [$clog2(N_TAPS)-1:0]   ld_addr,
  input  logic signed [DATA_W-1:0]    ld_data,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  output logic                        n_start,
  output logic signed [DATA_W-1:0]    n_x,
  output logic signed [DATA_W-1:0]    n_w,
  input  logic                        n_done,
  input  logic signed [ACC_W-1:0]     n_acc,
  input  logic signed [ACC_W-1:0]     n_relu,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic signed [ACC_W-1:0]     res_acc,
  output logic signed [ACC_W-1:0]     res_relu,
  output logic                        res_err,
  output logic                        busy
);
  import mac_pkg::*;
  localparam int AW = $clog2(N_TAPS);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  state_t state;
  logic [AW-1:0] k;
  logic [TW-1:0] tm;
  logic signed [DATA_W-1:0] rx, rw;
  logic we;
  // out-of-range addresses still handshake but never reach the register file
  assign we = ld_valid && state == IDLE && 32'(ld_addr) < N_TAPS;
  mac_operand_rf #(.N_TAPS(N_TAPS), .DATA_W(DATA_W)) u_rf (
    .clk(clk), .rst(rst), .we(we), .is_w(ld_is_w), .addr(ld_addr), .data(ld_data),
    .k(k), .x(rx), .w(rw)
  );
  assign ld_ready = state == IDLE;
  assign cmd_ready = state == IDLE && !ld_valid;
  assign n_start = state == START;
  assign n_x = state == FEED ? rx : '0;
  assign n_w = state == FEED ? rw : '0;
  assign res_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      tm <= '0;
      res_acc <= '0;
      res_relu <= '0;
      res_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid && cmd_ready) state <= START;
        START: state <= WAIT_CLR;
        WAIT_CLR: begin
          state <= FEED;
          k <= '0;
        end
        FEED: begin
          k <= k + 1'b1;
          if (k == AW'(N_TAPS - 1)) begin
            state <= WAIT_DONE;
            k <= '0;
            tm <= '0;
          end
        end
        WAIT_DONE: begin
          if (n_done) begin
            res_acc <= n_acc;
            res_relu <= n_relu;
            res_err <= 1'b0;
            state <= RESP;
          end else if (tm == TW'(DONE_TIMEOUT - 1)) begin
            res_acc <= '0;
            res_relu <= '0;
            res_err <= 1'b1;
            state <= RESP;
          end else tm <= tm + 1'b1;
        end
        RESP: if (res_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_neuron_feeder.sv
// tb_mac_neuron_feeder: directed bench with a behavioural neuron and a result scoreboard.
module tb_mac_neuron_feeder;
  import mac_pkg::*;
  localparam int N = 3, DW = 8, AW = 16, TO = 4;
  typedef struct {
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] relu;
    logic err;
    int lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic ld_valid = 1'b0, ld_ready, ld_is_w = 1'b0;
  logic [1:0] ld_addr = '0;
  logic signed [DW-1:0] ld_data = '0;
  logic cmd_valid = 1'b0, cmd_ready, n_start, n_done;
  logic signed [DW-1:0] n_x, n_w;
  logic signed [AW-1:0] n_acc, n_relu, res_acc, res_relu;
  logic res_valid, res_ready = 1'b0, res_err, busy;
  int total = 0, bad = 0;
  operand_t tx [N], tw [N];
  exp_t sb [$];
  logic no_done = 1'b0;
  logic [1:0] ph, j;
  logic signed [AW-1:0] acc;

  always #5 clk = ~clk;

  mac_neuron_feeder #(.N_TAPS(N), .DATA_W(DW), .ACC_W(AW), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_is_w(ld_is_w),
    .ld_addr(ld_addr), .ld_data(ld_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .n_start(n_start), .n_x(n_x), .n_w(n_w), .n_done(n_done), .n_acc(n_acc), .n_relu(n_relu),
    .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc), .res_relu(res_relu),
    .res_err(res_err), .busy(busy)
  );

  // neuron: start, one clear cycle, N MAC cycles, then a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ph <= 2'd0;
      j <= 2'd0;
      acc <= '0;
    end else begin
      case (ph)
        2'd0: if (n_start) ph <= 2'd1;
        2'd1: begin
          acc <= '0;
          j <= 2'd0;
          ph <= 2'd2;
        end
        2'd2: begin
          acc <= acc + 16'(n_x) * 16'(n_w);
          j <= j + 2'd1;
          if (j == 2'(N - 1)) ph <= 2'd3;
        end
        default: ph <= 2'd0;
      endcase
    end
  end
  assign n_done = ph == 2'd3 && !no_done;
  assign n_acc = acc;
  assign n_relu = acc < 0 ? '0 : acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic tmo);
    logic signed [AW-1:0] s;
    exp_t e;
    s = '0;
    for (int i = 0; i < N; i++) s = s + 16'(tx[i]) * 16'(tw[i]);
    e.acc = tmo ? '0 : s;
    e.relu = tmo ? '0 : (s < 0 ? '0 : s);
    e.err = tmo;
    e.lat = tmo ? TO : 1;
    return e;
  endfunction

  task automatic load(input logic is_w, input logic [1:0] a, input logic signed [DW-1:0] d);
    ld_valid = 1'b1;
    ld_is_w = is_w;
    ld_addr = a;
    ld_data = d;
    #1;
    chk("ld_ready", 32'(ld_ready), 1);
    tick();
    ld_valid = 1'b0;
    if (a < N) begin
      if (is_w) tw[a] = d;
      else tx[a] = d;
    end
  endtask

  task automatic run(input logic collide, input int hold);
    exp_t e;
    int n;
    if (collide) begin
      ld_valid = 1'b1;
      ld_is_w = 1'b0;
      ld_addr = 2'd3;
      ld_data = 8'sd77;
      cmd_valid = 1'b1;
      #1;
      chk("col_cmd_ready", 32'(cmd_ready), 0);
      chk("col_ld_ready", 32'(ld_ready), 1);
      tick();
      ld_valid = 1'b0;
    end
    cmd_valid = 1'b1;
    #1;
    chk("cmd_ready", 32'(cmd_ready), 1);
    chk("busy_idle", 32'(busy), 0);
    sb.push_back(model(no_done));
    tick();
    cmd_valid = 1'b0;
    chk("n_start", 32'(n_start), 1);
    chk("busy_run", 32'(busy), 1);
    tick();
    chk("n_start_pulse", 32'(n_start), 0);
    chk("clr_x", 32'(n_x), 0);
    for (int i = 0; i < N; i++) begin
      tick();
      chk("tap_x", 32'(n_x), 32'(tx[i]));
      chk("tap_w", 32'(n_w), 32'(tw[i]));
    end
    n = 0;
    tick();
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk("res_latency", n, e.lat);
    chk("res_valid", 32'(res_valid), 1);
    chk("res_acc", 32'(res_acc), 32'(e.acc));
    chk("res_relu", 32'(res_relu), 32'(e.relu));
    chk("res_err", 32'(res_err), 32'(e.err));
    chk("resp_cmd_ready", 32'(cmd_ready), 0);
    chk("resp_ld_ready", 32'(ld_ready), 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_acc", 32'(res_acc), 32'(e.acc));
      chk("hold_cmd_ready", 32'(cmd_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("ret_idle", 32'(busy), 0);
    chk("post_acc", 32'(res_acc), 32'(e.acc));
    chk("post_valid", 32'(res_valid), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      tx[i] = '0;
      tw[i] = '0;
    end
    tick();
    tick();
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_acc", 32'(res_acc), 0);
    chk("rst_res_err", 32'(res_err), 0);
    chk("rst_n_start", 32'(n_start), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    load(1'b0, 2'd0, 8'sd1); load(1'b0, 2'd1, 8'sd2); load(1'b0, 2'd2, 8'sd3);
    load(1'b1, 2'd0, 8'sd4); load(1'b1, 2'd1, 8'sd5); load(1'b1, 2'd2, 8'sd6);
    run(1'b0, 0);
    load(1'b0, 2'd0, -8'sd10); load(1'b0, 2'd1, 8'sd2); load(1'b0, 2'd2, 8'sd0);
    load(1'b1, 2'd0, 8'sd10); load(1'b1, 2'd1, 8'sd1); load(1'b1, 2'd2, 8'sd7);
    run(1'b0, 5);
    run(1'b1, 0);
    no_done = 1'b1;
    run(1'b0, 0);
    no_done = 1'b0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_tap1_x", 32'(n_x), 32'(tx[1]));
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_x", 32'(n_x), 0);
    chk("abort_w", 32'(n_w), 0);
    chk("abort_valid", 32'(res_valid), 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      tx[i] = '0;
      tw[i] = '0;
    end
    run(1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
